// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between
// instruction fetch and load/store with alternating arbitration.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_ack,
  output logic [31:0]      if_data,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_ack,
  output logic [31:0]      d_rdata,
  input  logic             halted,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        owner_d;
  logic        last_d;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        both;
  logic        pick_d;
  logic        grant;
  logic        in_access;
  logic        last_beat;

  // last_d low means the previous grant went to fetch
  assign both      = if_req & d_req;
  assign pick_d    = d_req & (~if_req | ~last_d);
  assign grant     = (state == IDLE) & ~halted
                   & (if_req | d_req);
  assign in_access = (state == ACCESS);
  assign last_beat = in_access & (cnt == 4'd0);

  assign busy      = (state != IDLE);
  assign if_ack    = (state == RESP) & ~owner_d;
  assign d_ack     = (state == RESP) & owner_d;
  assign mem_we    = last_beat & we_r;
  assign mem_addr  = in_access ? addr_r : '0;
  assign mem_wdata = in_access ? wdata_r : '0;

  // Sequencer: IDLE -> ACCESS for MEM_LAT cycles -> RESP
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= ACCESS;
            cnt   <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Latch winner and its operands at grant time
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      owner_d <= 1'b0;
      last_d  <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (grant) begin
      owner_d <= pick_d;
      last_d  <= pick_d;
      we_r    <= pick_d & d_we;
      addr_r  <= pick_d ? d_addr : if_addr;
      wdata_r <= d_wdata;
    end
  end

  // Capture read data into the owner's register on the last beat
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      if_data <= '0;
      d_rdata <= '0;
    end else if (last_beat && !we_r) begin
      if (owner_d) begin
        d_rdata <= mem_rdata;
      end else begin
        if_data <= mem_rdata;
      end
    end
  end

  // Saturating count of grants made under contention
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      conflict_cnt <= '0;
    end else if (grant && both && !(&conflict_cnt)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares one single-ported, fixed-latency 32-bit memory between the core's instruction-fetch requester and its load/store requester. It sits between the core and the memory model and serialises accesses with a req/ack handshake. It alternates fairly on conflicts and stops issuing new accesses once the core signals `halted`. It also keeps a saturating count of contended grants for performance debug.

## Interface
- `MEM_LAT`, default 2: memory access latency in cycles; legal range 1..15.
- `CNT_W`, default 16: width of the conflict counter.

- `clk` in 1: rising-edge clock.
- `rst_b` in 1: reset, asynchronous, active-low.
- `if_req` in 1: instruction fetch request; held until `if_ack`.
- `if_addr` in 32: fetch address; stable while `if_req` is high.
- `if_ack` out 1: one-cycle pulse; `if_data` is valid in the same cycle.
- `if_data` out 32: fetched instruction word.
- `d_req` in 1: data access request; held until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_ack` out 1: one-cycle pulse; `d_rdata` is valid in the same cycle for loads.
- `d_rdata` out 32: load data.
- `halted` in 1: when high, no new grant is issued.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_we` out 1: memory write strobe.
- `mem_rdata` in 32: memory read data; valid `MEM_LAT` cycles after the address is presented.
- `busy` out 1: high in any state other than IDLE.
- `conflict_cnt` out CNT_W: saturating count of grants made while both requests were pending.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- **IDLE, grant decision**
  - If `halted` = 0 and at least one request is pending, grant one requester.
  - Grant latches the address, `d_we` and `d_wdata` into internal registers, loads `cnt` = MEM_LAT-1, and moves to ACCESS.
- **Arbitration rules**
  - Only one request pending: that requester wins.
  - Both pending: the requester *not* recorded in `last_grant` wins, so grants alternate.
  - `last_grant` updates on every grant.
  - `conflict_cnt` increments on every grant made while both requests were pending; it saturates at all-ones.
- **ACCESS**
  - `mem_addr` and `mem_wdata` are driven from the latched registers for all MEM_LAT cycles.
  - `cnt` decrements every cycle.
  - When `cnt` = 0: for a store, `mem_we` = 1 for that cycle only; for a load or fetch, `mem_rdata` is captured into the owner's data register. The FSM then moves to RESP.
- **RESP**
  - Owner's ack = 1 for exactly one cycle, then the FSM returns to IDLE.
  - Requests are ignored in RESP; the requester must deassert req in the cycle after its ack.
  - A new request may be sampled in the following IDLE cycle.
- **Data outputs**
  - `if_data` and `d_rdata` hold their last captured value between accesses.
  - `d_rdata` is not updated by stores.
- **Halt behaviour**
  - An access already in flight when `halted` rises completes normally, including its ack.
  - Afterwards the FSM stays in IDLE indefinitely.
- **Address handling:** no address alignment or translation; addresses pass through unchanged.

## Timing
- **Reset values** (async, while `rst_b` = 0):
  - All outputs are 0: `if_ack`, `d_ack`, `mem_we`, `busy`, `mem_addr`, `mem_wdata`, `if_data`, `d_rdata`, `conflict_cnt`.
  - State = IDLE; `cnt` = 0.
  - `last_grant` = IF, so the first conflict after reset is granted to data.
- **Latency:** request sampled high in IDLE at edge k → ACCESS for edges k+1..k+MEM_LAT → ack high during cycle k+MEM_LAT+1.
  - Request-to-ack latency is therefore MEM_LAT+1 cycles.
  - Minimum period between grants is MEM_LAT+2 cycles.
- **MEM_LAT = 1:** ACCESS lasts one cycle, and `mem_we` / capture happen in that cycle.
- **Simultaneous events:** a request that rises in the same cycle as the other requester's ack waits for the next IDLE.
- **Reset mid-access:** the access is abandoned with no ack and `mem_we` forced to 0; the requester must re-issue after reset.
- **Latched operands:** changes on `if_addr`, `d_addr` or `d_wdata` after the grant have no effect on the access in progress.
- **Output sources:** all outputs are registered or decoded from state and registers only. There is no combinational path from any req input to any ack output.

## Test plan
- **Single fetch:** MEM_LAT=2; `if_req`=1 with `if_addr`=0x0000_0040 and memory returning 0x2008_0005.
  - Required: `mem_addr`=0x40 for 2 cycles, `if_ack` pulses 3 cycles after sampling, `if_data`=0x2008_0005.
- **Store then load:** store 0xDEAD_BEEF to 0x100, then load from 0x100.
  - Required: `mem_we` high for exactly 1 cycle and `d_rdata`=0xDEAD_BEEF.
- **Conflict alternation:** from reset, hold both reqs continuously for 4 grants.
  - Required: grant order D, IF, D, IF and `conflict_cnt`=4.
- **Halt mid-access:** raise `halted` during ACCESS of a fetch.
  - Required: that `if_ack` still pulses; afterwards no new grant for 20 cycles despite `d_req`=1, and `busy`=0.
- **Reset mid-access:** assert `rst_b`=0 during a store's ACCESS.
  - Required: all outputs go to 0 immediately, no ack, no `mem_we`.
- **Saturation and MEM_LAT=1:** with CNT_W=2, make 5 conflicting grants.
  - Required: `conflict_cnt` stays at 3, and request-to-ack is 2 cycles.
